// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: programmed count of counting-payload frames with
// per-frame tkeep/tlast, optional inter-frame gap and periodic bad-frame tuser.

module axis_frame_gen_lane #(
  parameter int LANE = 0
) (
  input  logic [7:0] base,
  input  logic       keep,
  output logic [7:0] lane_byte
);
  assign lane_byte = keep ? base + 8'(LANE) : 8'd0;
endmodule

module axis_frame_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [CNT_WIDTH-1:0]  frame_count,
  input  logic [7:0]            gap_cycles,
  input  logic [7:0]            bad_period,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);
  localparam int LG = $clog2(KEEP_WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state;

  logic [LEN_WIDTH-1:0] len_q, w_q, beat_rem;
  logic [CNT_WIDTH-1:0] count_q, frame_idx;
  logic [7:0]           gap_q, bad_q, gap_cnt, bad_cnt, next_base;
  logic                 abort_pend;

  logic [LEN_WIDTH-1:0] w_start;
  logic                 hs, last_frame, stop, start_ok;
  logic [7:0]           nxt_bad;

  assign w_start    = LEN_WIDTH'(({1'b0, frame_len} + (LEN_WIDTH+1)'(KEEP_WIDTH-1)) >> LG);
  assign hs         = m_axis_tvalid & m_axis_tready;
  assign last_frame = ({1'b0, frame_idx} + (CNT_WIDTH+1)'(1)) == {1'b0, count_q};
  assign stop       = last_frame | abort_pend | abort;
  assign nxt_bad    = (bad_cnt <= 8'd1) ? bad_q : bad_cnt - 8'd1;
  assign start_ok   = start && (frame_len != '0) && (frame_count != '0);

  // Next beat to present: either the following beat of this frame or the
  // first beat of a new frame (from IDLE, back-to-back, or end of GAP).
  logic [LEN_WIDTH-1:0]        ld_len, rem;
  logic [7:0]                  ld_base;
  logic                        ld_last, ld_user, do_load, do_clear;
  logic [KEEP_WIDTH-1:0]       ld_keep;
  logic [KEEP_WIDTH-1:0][7:0]  ld_data;

  always_comb begin
    ld_len  = len_q;
    ld_base = next_base;
    ld_last = (beat_rem == LEN_WIDTH'(1));
    ld_user = ld_last && (bad_q != 8'd0) && (bad_cnt == 8'd1);
    case (state)
      IDLE: begin
        ld_len  = frame_len;
        ld_base = 8'd0;
        ld_last = (w_start == LEN_WIDTH'(1));
        ld_user = ld_last && (bad_period == 8'd1);
      end
      SEND: if (m_axis_tlast) begin
        ld_base = frame_idx[7:0] + 8'd1;
        ld_last = (w_q == LEN_WIDTH'(1));
        ld_user = ld_last && (bad_q != 8'd0) && (nxt_bad == 8'd1);
      end
      GAP: begin
        ld_base = frame_idx[7:0];
        ld_last = (w_q == LEN_WIDTH'(1));
        ld_user = ld_last && (bad_q != 8'd0) && (bad_cnt == 8'd1);
      end
      default: ;
    endcase
    rem = ld_len & LEN_WIDTH'(KEEP_WIDTH-1);
    for (int i = 0; i < KEEP_WIDTH; i++)
      ld_keep[i] = !ld_last || (rem == '0) || (LEN_WIDTH'(i) < rem);
  end

  always_comb begin
    do_load  = 1'b0;
    do_clear = 1'b0;
    case (state)
      IDLE: do_load = start_ok;
      SEND: if (hs) begin
        do_load  = !m_axis_tlast || (!stop && gap_q == 8'd0);
        do_clear = m_axis_tlast && (stop || gap_q != 8'd0);
      end
      GAP:  do_load = !(abort || abort_pend) && (gap_cnt == 8'd1);
      default: ;
    endcase
  end

  for (genvar g = 0; g < KEEP_WIDTH; g++) begin : g_lane
    axis_frame_gen_lane #(.LANE(g)) u_lane (
      .base      (ld_base),
      .keep      (ld_keep[g]),
      .lane_byte (ld_data[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frames_sent   <= '0;
      len_q         <= '0;
      w_q           <= '0;
      beat_rem      <= '0;
      count_q       <= '0;
      frame_idx     <= '0;
      gap_q         <= 8'd0;
      bad_q         <= 8'd0;
      gap_cnt       <= 8'd0;
      bad_cnt       <= 8'd0;
      next_base     <= 8'd0;
      abort_pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (do_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ld_data;
        m_axis_tkeep  <= ld_keep;
        m_axis_tlast  <= ld_last;
        m_axis_tuser  <= ld_user;
        next_base     <= ld_base + 8'(KEEP_WIDTH);
      end else if (do_clear) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tdata  <= '0;
        m_axis_tkeep  <= '0;
        m_axis_tlast  <= 1'b0;
        m_axis_tuser  <= 1'b0;
      end
      case (state)
        IDLE: if (start_ok) begin
          len_q       <= frame_len;
          count_q     <= frame_count;
          gap_q       <= gap_cycles;
          bad_q       <= bad_period;
          bad_cnt     <= bad_period;
          w_q         <= w_start;
          beat_rem    <= w_start - LEN_WIDTH'(1);
          frame_idx   <= '0;
          frames_sent <= '0;
          abort_pend  <= 1'b0;
          busy        <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (hs) begin
            if (!m_axis_tlast) begin
              beat_rem <= beat_rem - LEN_WIDTH'(1);
            end else begin
              if (frames_sent != '1) frames_sent <= frames_sent + CNT_WIDTH'(1);
              if (stop) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                frame_idx <= frame_idx + CNT_WIDTH'(1);
                bad_cnt   <= nxt_bad;
                if (gap_q == 8'd0) begin
                  beat_rem <= w_q - LEN_WIDTH'(1);
                end else begin
                  gap_cnt <= gap_q;
                  state   <= GAP;
                end
              end
            end
          end
        end
        GAP: begin
          if (abort || abort_pend) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (gap_cnt == 8'd1) begin
            beat_rem <= w_q - LEN_WIDTH'(1);
            state    <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomized bench for axis_frame_gen against a byte-level frame model.

module tb_axis_frame_gen;
  localparam int DW = 32, KW = 4, LW = 16, CW = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [CW-1:0] frame_count = '0;
  logic [7:0]    gap_cycles = '0, bad_period = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, done;
  logic          m_axis_tready = 1'b1;
  logic [CW-1:0] frames_sent;
  bit            rand_rdy = 1'b0;

  axis_frame_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_len(frame_len), .frame_count(frame_count),
    .gap_cycles(gap_cycles), .bad_period(bad_period),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  beat_t exp_q[$], got_q[$];
  int    got_cyc[$];
  int    cyc = 0, done_cnt = 0, done_cyc = 0, stab_err = 0, busy_seen = 0;
  int    pass_cnt = 0, chk_cnt = 0, st_cyc = 0;
  beat_t prev_b;
  logic  prev_stall = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Bus monitor: records handshakes, done pulses and AXI hold violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!m_axis_tvalid ||
          {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} != prev_b))
        stab_err <= stab_err + 1;
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_b     <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (busy) busy_seen <= busy_seen + 1;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  // Reference: byte k of frame n is (n+k) mod 256, packed KW bytes per beat.
  task automatic build_exp(input int len, input int nfr, input int bp);
    exp_q.delete();
    for (int n = 0; n < nfr; n++)
      for (int b = 0; b * KW < len; b++) begin
        beat_t e;
        e = '0;
        for (int j = 0; j < KW; j++) begin
          int k;
          k = b * KW + j;
          if (k < len) begin
            e.k[j]       = 1'b1;
            e.d[8*j +: 8] = 8'((n + k) % 256);
          end
        end
        e.l = ((b + 1) * KW >= len);
        e.u = e.l && (bp != 0) && (((n + 1) % bp) == 0);
        exp_q.push_back(e);
      end
  endtask

  task automatic do_start(input int len, input int cnt, input int gap, input int bp, input bit ab);
    @(posedge clk); #1;
    frame_len   = LW'(len);
    frame_count = CW'(cnt);
    gap_cycles  = 8'(gap);
    bad_period  = 8'(bp);
    start       = 1'b1;
    abort       = ab;
    st_cyc      = cyc;
    @(posedge clk); #1;
    start       = 1'b0;
    abort       = 1'b0;
    frame_len   = LW'($urandom);
    frame_count = CW'($urandom);
    gap_cycles  = 8'($urandom);
    bad_period  = 8'($urandom);
  endtask

  task automatic wait_done(input int d0, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk); #1;
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep, busy, done, frames_sent} !== '0)
      $display("FAIL reset_values: got %h, expected 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep, busy, done, frames_sent});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int b0, d0, nb;
    bit ok;
    b0 = got_q.size(); d0 = done_cnt;
    build_exp(6, 2, 0);
    do_start(6, 2, 0, 0, 1'b0);
    wait_done(d0, 200, ok);
    chk_cnt++; if (!ok) $display("FAIL basic_timeout: got no done, expected done"); else pass_cnt++;
    nb = got_q.size() - b0;
    chk_cnt++; if (nb !== exp_q.size()) $display("FAIL basic_count: got %0d, expected %0d", nb, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[b0+i] !== exp_q[i]) $display("FAIL basic_beat%0d: got %h, expected %h", i, got_q[b0+i], exp_q[i]);
      else pass_cnt++;
    end
    if (nb == 4) begin
      chk_cnt++;
      if (got_q[b0+1] !== {32'h0000_0504, 4'h3, 1'b1, 1'b0})
        $display("FAIL basic_beat1_const: got %h, expected %h", got_q[b0+1], {32'h0000_0504, 4'h3, 1'b1, 1'b0});
      else pass_cnt++;
      chk_cnt++;
      if (got_cyc[b0] !== st_cyc + 1) $display("FAIL basic_latency: got %0d, expected %0d", got_cyc[b0], st_cyc + 1);
      else pass_cnt++;
      chk_cnt++;
      if (got_cyc[b0+3] - got_cyc[b0] !== 3) $display("FAIL basic_throughput: got %0d, expected 3", got_cyc[b0+3] - got_cyc[b0]);
      else pass_cnt++;
      chk_cnt++;
      if (done_cyc !== got_cyc[b0+3] + 1) $display("FAIL basic_done_cycle: got %0d, expected %0d", done_cyc, got_cyc[b0+3] + 1);
      else pass_cnt++;
    end
    chk_cnt++; if (frames_sent !== 16'd2) $display("FAIL basic_frames_sent: got %0d, expected 2", frames_sent); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_low: got %b, expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_gap_bad;
    int b0, d0, nb;
    bit ok;
    b0 = got_q.size(); d0 = done_cnt;
    build_exp(8, 3, 2);
    do_start(8, 3, 4, 2, 1'b0);
    wait_done(d0, 300, ok);
    chk_cnt++; if (!ok) $display("FAIL gap_timeout: got no done, expected done"); else pass_cnt++;
    nb = got_q.size() - b0;
    chk_cnt++; if (nb !== exp_q.size()) $display("FAIL gap_count: got %0d, expected %0d", nb, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[b0+i] !== exp_q[i]) $display("FAIL gap_beat%0d: got %h, expected %h", i, got_q[b0+i], exp_q[i]);
      else pass_cnt++;
    end
    if (nb == 6)
      for (int f = 1; f < 3; f++) begin
        chk_cnt++;
        if (got_cyc[b0+2*f] - got_cyc[b0+2*f-1] !== 5)
          $display("FAIL gap_spacing%0d: got %0d, expected 5", f, got_cyc[b0+2*f] - got_cyc[b0+2*f-1]);
        else pass_cnt++;
      end
    chk_cnt++; if (frames_sent !== 16'd3) $display("FAIL gap_frames_sent: got %0d, expected 3", frames_sent); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    int b0, d0, nb, s0;
    bit ok;
    b0 = got_q.size(); d0 = done_cnt; s0 = stab_err;
    rand_rdy = 1'b1;
    build_exp(16, 1, 0);
    do_start(16, 1, 0, 0, 1'b0);
    wait_done(d0, 300, ok);
    rand_rdy = 1'b0;
    chk_cnt++; if (!ok) $display("FAIL bp_timeout: got no done, expected done"); else pass_cnt++;
    nb = got_q.size() - b0;
    chk_cnt++; if (nb !== exp_q.size()) $display("FAIL bp_count: got %0d, expected %0d", nb, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[b0+i] !== exp_q[i]) $display("FAIL bp_beat%0d: got %h, expected %h", i, got_q[b0+i], exp_q[i]);
      else pass_cnt++;
    end
    if (nb == 4) begin
      chk_cnt++;
      if (got_q[b0+3].d !== 32'h0F0E_0D0C) $display("FAIL bp_last_data: got %h, expected 0f0e0d0c", got_q[b0+3].d);
      else pass_cnt++;
    end
    chk_cnt++; if (stab_err !== s0) $display("FAIL bp_hold_stable: got %0d violations, expected 0", stab_err - s0); else pass_cnt++;
  endtask

  task automatic test_abort;
    int b0, d0, nb;
    bit ok, hit;
    b0 = got_q.size(); d0 = done_cnt; hit = 1'b0;
    build_exp(5, 4, 0);
    do_start(5, 100, 0, 0, 1'b0);
    for (int i = 0; i < 200 && !hit; i++) begin
      if (frames_sent == 16'd3 && m_axis_tvalid && m_axis_tlast) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk_cnt++; if (!hit) $display("FAIL abort_reach_frame3: got no frame3 tlast, expected one"); else pass_cnt++;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(d0, 300, ok);
    chk_cnt++; if (!ok) $display("FAIL abort_timeout: got no done, expected done"); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    nb = got_q.size() - b0;
    chk_cnt++; if (nb !== exp_q.size()) $display("FAIL abort_count: got %0d, expected %0d", nb, exp_q.size()); else pass_cnt++;
    for (int i = 0; i < nb && i < exp_q.size(); i++) begin
      chk_cnt++;
      if (got_q[b0+i] !== exp_q[i]) $display("FAIL abort_beat%0d: got %h, expected %h", i, got_q[b0+i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (frames_sent !== 16'd4) $display("FAIL abort_frames_sent: got %0d, expected 4", frames_sent); else pass_cnt++;
    chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL abort_done_pulses: got %0d, expected 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int b0, d0, nb;
    bit ok;
    d0 = done_cnt;
    do_start(40, 3, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk_cnt++; if (m_axis_tvalid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b, expected 1", m_axis_tvalid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep, busy, done, frames_sent} !== '0)
      $display("FAIL rstmid_async_clear: got %h, expected 0",
               {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tkeep, busy, done, frames_sent});
    else pass_cnt++;
    @(posedge clk); #1 rst_n = 1'b1;
    d0 = done_cnt;
    b0 = got_q.size();
    do_start(4, 1, 0, 0, 1'b0);
    wait_done(d0, 100, ok);
    chk_cnt++; if (!ok) $display("FAIL rstmid_timeout: got no done, expected done"); else pass_cnt++;
    nb = got_q.size() - b0;
    chk_cnt++; if (nb !== 1) $display("FAIL rstmid_count: got %0d, expected 1", nb); else pass_cnt++;
    if (nb >= 1) begin
      chk_cnt++;
      if (got_q[b0] !== {32'h0302_0100, 4'hF, 1'b1, 1'b0})
        $display("FAIL rstmid_beat: got %h, expected %h", got_q[b0], {32'h0302_0100, 4'hF, 1'b1, 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_params;
    int b0, d0, bs0;
    logic [CW-1:0] fs0;
    b0 = got_q.size(); d0 = done_cnt; bs0 = busy_seen; fs0 = frames_sent;
    do_start(0, 3, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    do_start(4, 0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++; if (busy_seen !== bs0) $display("FAIL zero_busy: got %0d busy cycles, expected 0", busy_seen - bs0); else pass_cnt++;
    chk_cnt++; if (got_q.size() !== b0) $display("FAIL zero_beats: got %0d, expected 0", got_q.size() - b0); else pass_cnt++;
    chk_cnt++; if (done_cnt !== d0) $display("FAIL zero_done: got %0d, expected 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (frames_sent !== fs0) $display("FAIL zero_frames_sent: got %0d, expected %0d", frames_sent, fs0); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 6; r++) begin
      int b0, d0, nb, len, cnt, gap, bp;
      bit ok;
      len = int'($urandom_range(1, 23));
      cnt = int'($urandom_range(1, 4));
      gap = int'($urandom_range(0, 3));
      bp  = int'($urandom_range(0, 3));
      b0 = got_q.size(); d0 = done_cnt;
      rand_rdy = 1'b1;
      build_exp(len, cnt, bp);
      // abort alongside start in IDLE must neither block nor shorten the run
      do_start(len, cnt, gap, bp, r == 0);
      wait_done(d0, 1000, ok);
      rand_rdy = 1'b0;
      chk_cnt++; if (!ok) $display("FAIL rand%0d_timeout: got no done, expected done", r); else pass_cnt++;
      nb = got_q.size() - b0;
      chk_cnt++; if (nb !== exp_q.size()) $display("FAIL rand%0d_count: got %0d, expected %0d", r, nb, exp_q.size()); else pass_cnt++;
      for (int i = 0; i < nb && i < exp_q.size(); i++) begin
        chk_cnt++;
        if (got_q[b0+i] !== exp_q[i]) $display("FAIL rand%0d_beat%0d: got %h, expected %h", r, i, got_q[b0+i], exp_q[i]);
        else pass_cnt++;
      end
      chk_cnt++;
      if (frames_sent !== CW'(cnt)) $display("FAIL rand%0d_frames_sent: got %0d, expected %0d", r, frames_sent, cnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gap_bad;
    test_backpressure;
    test_abort;
    test_reset_mid;
    test_zero_params;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
